// File: rtl/maxpool2x2_stream_if.sv
// Stream bundle between the conv layer, the 2x2 pooling block and the next IFM memory.
// The slave side consumes conv samples and produces pooled writes.
interface maxpool2x2_stream_if #(
  parameter int unsigned IN_W   = 32,
  parameter int unsigned OUT_W  = 16,
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned CH_W   = 5
);
  logic signed [IN_W-1:0]  in_data;
  logic                    in_valid;
  logic signed [OUT_W-1:0] out_data;
  logic [ADDR_W-1:0]       out_addr;
  logic [CH_W-1:0]         out_chan;
  logic                    out_valid;

  modport master (
    output in_data,
    output in_valid,
    input  out_data,
    input  out_addr,
    input  out_chan,
    input  out_valid
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output out_data,
    output out_addr,
    output out_chan,
    output out_valid
  );
endinterface

// File: rtl/maxpool2x2_stream.sv
// 2x2 stride-2 max pooling over a channel-major, row, column sample stream with no backpressure.
// Emits each saturated pooled value with its pixel address and channel one cycle after completion.
module maxpool2x2_stream #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned HEIGHT   = 16,
  parameter int unsigned CHANNELS = 32,
  parameter int unsigned IN_W     = 32,
  parameter int unsigned OUT_W    = 16,
  parameter int unsigned ADDR_W   = 6,
  parameter int unsigned CH_W     = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  maxpool2x2_stream_if.slave    strm,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned HalfW = WIDTH / 2;
  localparam int unsigned ColW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned RowW  = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int unsigned BufAw = (HalfW > 1) ? $clog2(HalfW) : 1;

  localparam logic signed [IN_W-1:0] SatMax = IN_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
  localparam logic signed [IN_W-1:0] SatMin = ~SatMax;

  if (WIDTH % 2 != 0) begin : g_bad_width
    $error("maxpool2x2_stream: WIDTH must be even");
  end
  if (HEIGHT % 2 != 0) begin : g_bad_height
    $error("maxpool2x2_stream: HEIGHT must be even");
  end
  if ((2 ** ADDR_W) < (HalfW * (HEIGHT / 2))) begin : g_bad_addr_w
    $error("maxpool2x2_stream: ADDR_W too small for pooled map");
  end
  if ((2 ** CH_W) < CHANNELS) begin : g_bad_ch_w
    $error("maxpool2x2_stream: CH_W too small for CHANNELS");
  end

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e state_q, state_d;

  logic [ColW-1:0]  col_q, col_d;
  logic [RowW-1:0]  row_q, row_d;
  logic [CH_W-1:0]  chan_q, chan_d;
  logic signed [IN_W-1:0] hmax_q, hmax_d;
  logic signed [IN_W-1:0] rowbuf_q [HalfW];

  logic signed [OUT_W-1:0] out_data_q, out_data_d;
  logic [ADDR_W-1:0]       out_addr_q, out_addr_d;
  logic [CH_W-1:0]         out_chan_q, out_chan_d;
  logic                    out_valid_q, out_valid_d;

  logic                   accept, clear;
  logic                   col_last, row_last, chan_last, last_accept;
  logic [BufAw-1:0]       buf_idx;
  logic signed [IN_W-1:0] d, pair_max, pool_max;

  function automatic logic signed [IN_W-1:0] smax(input logic signed [IN_W-1:0] a,
                                                  input logic signed [IN_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic signed [OUT_W-1:0] sat(input logic signed [IN_W-1:0] p);
    if (p > SatMax) begin
      return {1'b0, {(OUT_W - 1){1'b1}}};
    end else if (p < SatMin) begin
      return {1'b1, {(OUT_W - 1){1'b0}}};
    end
    return p[OUT_W-1:0];
  endfunction

  // ---------------------------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StRun;
      StRun:   if (last_accept) state_d = StDone;
      StDone:  if (start) state_d = StRun;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy   = (state_q == StRun);
    done   = (state_q == StDone);
    accept = (state_q == StRun) && strm.in_valid;
    clear  = start && (state_q != StRun);
  end

  // ---------------------------------------------------------------------------------------------
  // Scan counters
  // ---------------------------------------------------------------------------------------------
  assign col_last    = (col_q == ColW'(WIDTH - 1));
  assign row_last    = (row_q == RowW'(HEIGHT - 1));
  assign chan_last   = (chan_q == CH_W'(CHANNELS - 1));
  assign last_accept = accept && col_last && row_last && chan_last;

  always_comb begin
    col_d  = col_q;
    row_d  = row_q;
    chan_d = chan_q;
    if (clear) begin
      col_d  = '0;
      row_d  = '0;
      chan_d = '0;
    end else if (accept) begin
      if (col_last) begin
        col_d = '0;
        if (row_last) begin
          row_d  = '0;
          chan_d = chan_last ? '0 : chan_q + 1'b1;
        end else begin
          row_d = row_q + 1'b1;
        end
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Pooling datapath
  // ---------------------------------------------------------------------------------------------
  assign d        = strm.in_data;
  assign buf_idx  = BufAw'(col_q >> 1);
  assign pair_max = smax(hmax_q, d);
  // Odd rows only ever read slots written earlier in the same row pair, so no reset is needed.
  assign pool_max = smax(rowbuf_q[buf_idx], pair_max);

  always_comb begin
    hmax_d      = hmax_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    out_addr_d  = out_addr_q;
    out_chan_d  = out_chan_q;
    if (accept && !col_q[0]) begin
      hmax_d = d;
    end
    if (accept && col_q[0] && row_q[0]) begin
      out_valid_d = 1'b1;
      out_data_d  = sat(pool_max);
      out_addr_d  = ADDR_W'(32'(row_q >> 1) * HalfW + 32'(col_q >> 1));
      out_chan_d  = chan_q;
    end
  end

  always_ff @(posedge clk) begin
    if (accept && col_q[0] && !row_q[0]) begin
      rowbuf_q[buf_idx] <= pair_max;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q       <= '0;
      row_q       <= '0;
      chan_q      <= '0;
      hmax_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_addr_q  <= '0;
      out_chan_q  <= '0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      chan_q      <= chan_d;
      hmax_q      <= hmax_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_addr_q  <= out_addr_d;
      out_chan_q  <= out_chan_d;
    end
  end

  assign strm.out_valid = out_valid_q;
  assign strm.out_data  = out_data_q;
  assign strm.out_addr  = out_addr_q;
  assign strm.out_chan  = out_chan_q;

endmodule

// File: tb/tb_maxpool2x2_stream.sv
// Randomized scoreboard bench for maxpool2x2_stream: a frame-array reference model
// pushes expected pooled writes, and a negedge monitor pops and compares them.
module tb_maxpool2x2_stream;
  localparam int W = 16;
  localparam int H = 16;
  localparam int C = 32;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic busy;
  logic done;

  maxpool2x2_stream_if #(.IN_W(32), .OUT_W(16), .ADDR_W(6), .CH_W(5)) bus ();

  maxpool2x2_stream #(
    .WIDTH(W), .HEIGHT(H), .CHANNELS(C), .IN_W(32), .OUT_W(16), .ADDR_W(6), .CH_W(5)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .strm(bus), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int data;
    int addr;
    int chan;
    int cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   outs = 0;
  int   exp_outs = 0;
  int   fr [C][H][W];
  int   sat_a [4] = '{40000, 5, 6, 7};
  int   sat_b [4] = '{-3, -9, -1, -20};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic int sat16(input longint p);
    if (p > 32767) return 32767;
    if (p < -32768) return -32768;
    return int'(p);
  endfunction

  function automatic longint max4(input int c, input int r, input int x);
    longint m;
    m = fr[c][r-1][x-1];
    if (fr[c][r-1][x] > m) m = fr[c][r-1][x];
    if (fr[c][r][x-1] > m) m = fr[c][r][x-1];
    if (fr[c][r][x] > m) m = fr[c][r][x];
    return m;
  endfunction

  // kind 0: ramp, 1: directed windows (single 100s, saturation cases), 2: random
  task automatic fill(input int kind);
    for (int c = 0; c < C; c++) begin
      for (int r = 0; r < H; r++) begin
        for (int x = 0; x < W; x++) begin
          int v;
          v = int'($urandom) >>> $urandom_range(0, 20);
          if (kind == 0) begin
            v = c * 256 + r * 16 + x;
          end else if (kind == 1 && c < 4) begin
            v = (r == c / 2 && x == c % 2) ? 100 : 0;
          end else if (kind == 1 && c == 4) begin
            v = 0;
            if (r < 2 && x / 2 == 0) v = sat_a[r * 2 + x % 2];
            if (r < 2 && x / 2 == 1) v = -70000;
            if (r < 2 && x / 2 == 2) v = sat_b[r * 2 + x % 2];
          end
          fr[c][r][x] = v;
        end
      end
    end
  endtask

  task automatic do_start();
    @(posedge clk); #1;
    start = 1'b1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("done_drops_after_start", done, 0);
  endtask

  task automatic run_frame(input bit sparse, input int abort_at, input bit poke_start);
    int idx;
    idx = 0;
    for (int c = 0; c < C; c++) begin
      for (int r = 0; r < H; r++) begin
        for (int x = 0; x < W; x++) begin
          if (sparse) begin
            repeat ($urandom_range(2, 4)) begin
              @(posedge clk); #1;
              bus.in_valid = 1'b0;
              bus.in_data  = $urandom;
            end
          end
          @(posedge clk); #1;
          if (poke_start && idx == 502) chk("start_in_run_ignored_busy", busy, 1);
          bus.in_valid = 1'b1;
          bus.in_data  = fr[c][r][x];
          start        = poke_start && (idx == 500);
          if (r % 2 == 1 && x % 2 == 1) begin
            sb.push_back('{sat16(max4(c, r, x)), (r / 2) * 8 + x / 2, c, cyc + 1});
            exp_outs++;
          end
          if (idx == abort_at) begin
            @(posedge clk); #1;
            rst = 1'b1;
            bus.in_valid = 1'b0;
            start = 1'b0;
            exp_outs -= sb.size();
            sb.delete();
            @(negedge clk);
            chk("abort_out_data", bus.out_data, 0);
            chk("abort_out_addr", bus.out_addr, 0);
            chk("abort_out_chan", bus.out_chan, 0);
            chk("abort_out_valid", bus.out_valid, 0);
            chk("abort_busy", busy, 0);
            chk("abort_done", done, 0);
            @(posedge clk); #1;
            rst = 1'b0;
            return;
          end
          idx++;
        end
      end
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("final_out_valid", bus.out_valid, 1);
    chk("done_with_final_output", done, 1);
    chk("busy_low_with_final_output", busy, 0);
    @(posedge clk); #1;
    chk("scoreboard_drained", sb.size(), 0);
  endtask

  always @(negedge clk) begin
    if (bus.out_valid === 1'b1) begin
      outs++;
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_out_valid: actual chan=%0d addr=%0d, required no output",
                 bus.out_chan, bus.out_addr);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("out_data", $signed(bus.out_data), e.data);
        chk("out_addr", bus.out_addr, e.addr);
        chk("out_chan", bus.out_chan, e.chan);
        chk("out_latency_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    start = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    repeat (2) @(negedge clk);
    chk("reset_out_data", bus.out_data, 0);
    chk("reset_out_addr", bus.out_addr, 0);
    chk("reset_out_chan", bus.out_chan, 0);
    chk("reset_out_valid", bus.out_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Samples while idle must not advance anything.
    repeat (3) begin
      @(posedge clk); #1;
      bus.in_valid = 1'b1;
      bus.in_data  = $urandom;
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);

    fill(0);
    do_start();
    run_frame(1'b0, -1, 1'b1);

    repeat (3) @(posedge clk);
    #1;
    chk("done_held_until_start", done, 1);

    fill(1);
    do_start();
    run_frame(1'b0, -1, 1'b0);

    fill(0);
    do_start();
    run_frame(1'b1, -1, 1'b0);

    fill(2);
    do_start();
    run_frame(1'b0, -1, 1'b0);

    fill(0);
    do_start();
    run_frame(1'b0, 999, 1'b0);
    do_start();
    run_frame(1'b0, -1, 1'b0);

    repeat (2) @(posedge clk);
    #1;
    chk("total_outputs", outs, exp_outs);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
